// File: rtl/dmem_axi_arbiter.sv
// dmem_axi_arbiter: round-robin arbiter giving two AXI4-Lite masters one whole transaction at a time on a shared memory port
module dmem_axi_arbiter #(
  parameter int AXI_AWIDTH = 4,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESET,
  input  logic [AXI_AWIDTH-1:0]   S0_AWADDR,
  input  logic                    S0_AWVALID,
  output logic                    S0_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   S0_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] S0_WSTRB,
  input  logic                    S0_WVALID,
  output logic                    S0_WREADY,
  output logic [1:0]              S0_BRESP,
  output logic                    S0_BVALID,
  input  logic                    S0_BREADY,
  input  logic [AXI_AWIDTH-1:0]   S0_ARADDR,
  input  logic                    S0_ARVALID,
  output logic                    S0_ARREADY,
  output logic [AXI_DWIDTH-1:0]   S0_RDATA,
  output logic [1:0]              S0_RRESP,
  output logic                    S0_RVALID,
  input  logic                    S0_RREADY,
  input  logic [AXI_AWIDTH-1:0]   S1_AWADDR,
  input  logic                    S1_AWVALID,
  output logic                    S1_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   S1_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] S1_WSTRB,
  input  logic                    S1_WVALID,
  output logic                    S1_WREADY,
  output logic [1:0]              S1_BRESP,
  output logic                    S1_BVALID,
  input  logic                    S1_BREADY,
  input  logic [AXI_AWIDTH-1:0]   S1_ARADDR,
  input  logic                    S1_ARVALID,
  output logic                    S1_ARREADY,
  output logic [AXI_DWIDTH-1:0]   S1_RDATA,
  output logic [1:0]              S1_RRESP,
  output logic                    S1_RVALID,
  input  logic                    S1_RREADY,
  output logic [AXI_AWIDTH-1:0]   M_AWADDR,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [AXI_DWIDTH-1:0]   M_WDATA,
  output logic [AXI_DWIDTH/8-1:0] M_WSTRB,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  output logic [AXI_AWIDTH-1:0]   M_ARADDR,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RVALID,
  output logic                    M_RREADY,
  output logic [1:0]              GRANT,
  output logic                    BUSY
);
  typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RDATA} state_t;
  state_t r_state, w_next;
  logic [1:0] r_grant;
  logic r_ptr, r_aw_done, r_w_done;
  logic w_req0, w_req1, w_win, w_win_aw, w_sel;
  logic w_in_wr, w_in_wresp, w_in_rd, w_in_rdata;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_wr_end, w_done;
  logic [AXI_AWIDTH-1:0] w_awaddr, w_araddr;
  logic [AXI_DWIDTH-1:0] w_wdata, w_rdata;
  logic [AXI_DWIDTH/8-1:0] w_wstrb;
  logic [1:0] w_bresp, w_rresp;
  logic w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;
  logic w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
  assign w_req0 = S0_AWVALID | S0_ARVALID;
  assign w_req1 = S1_AWVALID | S1_ARVALID;
  assign w_win = (w_req0 & w_req1) ? r_ptr : w_req1;
  assign w_win_aw = w_win ? S1_AWVALID : S0_AWVALID;
  assign w_sel = r_grant[1];
  assign w_in_wr = r_state == WR;
  assign w_in_wresp = r_state == WRESP;
  assign w_in_rd = r_state == RD;
  assign w_in_rdata = r_state == RDATA;
  assign w_awaddr = w_sel ? S1_AWADDR : S0_AWADDR;
  assign w_awvalid = w_sel ? S1_AWVALID : S0_AWVALID;
  assign w_wdata = w_sel ? S1_WDATA : S0_WDATA;
  assign w_wstrb = w_sel ? S1_WSTRB : S0_WSTRB;
  assign w_wvalid = w_sel ? S1_WVALID : S0_WVALID;
  assign w_bready = w_sel ? S1_BREADY : S0_BREADY;
  assign w_araddr = w_sel ? S1_ARADDR : S0_ARADDR;
  assign w_arvalid = w_sel ? S1_ARVALID : S0_ARVALID;
  assign w_rready = w_sel ? S1_RREADY : S0_RREADY;
  // a channel that already handshook is closed until the write ends
  assign M_AWVALID = w_in_wr & w_awvalid & ~r_aw_done;
  assign M_AWADDR = w_in_wr ? w_awaddr : '0;
  assign M_WVALID = w_in_wr & w_wvalid & ~r_w_done;
  assign M_WDATA = w_in_wr ? w_wdata : '0;
  assign M_WSTRB = w_in_wr ? w_wstrb : '0;
  assign M_BREADY = w_in_wresp & w_bready;
  assign M_ARVALID = w_in_rd & w_arvalid;
  assign M_ARADDR = w_in_rd ? w_araddr : '0;
  // the memory looks at RREADY already in its ARREADY cycle
  assign M_RREADY = (w_in_rd | w_in_rdata) & w_rready;
  assign w_awready = w_in_wr & M_AWREADY & ~r_aw_done;
  assign w_wready = w_in_wr & M_WREADY & ~r_w_done;
  assign w_bvalid = w_in_wresp & M_BVALID;
  assign w_bresp = w_in_wresp ? M_BRESP : '0;
  assign w_arready = w_in_rd & M_ARREADY;
  assign w_rvalid = w_in_rdata & M_RVALID;
  assign w_rdata = w_in_rdata ? M_RDATA : '0;
  assign w_rresp = w_in_rdata ? M_RRESP : '0;
  assign S0_AWREADY = r_grant[0] & w_awready;
  assign S0_WREADY = r_grant[0] & w_wready;
  assign S0_BVALID = r_grant[0] & w_bvalid;
  assign S0_BRESP = r_grant[0] ? w_bresp : '0;
  assign S0_ARREADY = r_grant[0] & w_arready;
  assign S0_RVALID = r_grant[0] & w_rvalid;
  assign S0_RDATA = r_grant[0] ? w_rdata : '0;
  assign S0_RRESP = r_grant[0] ? w_rresp : '0;
  assign S1_AWREADY = r_grant[1] & w_awready;
  assign S1_WREADY = r_grant[1] & w_wready;
  assign S1_BVALID = r_grant[1] & w_bvalid;
  assign S1_BRESP = r_grant[1] ? w_bresp : '0;
  assign S1_ARREADY = r_grant[1] & w_arready;
  assign S1_RVALID = r_grant[1] & w_rvalid;
  assign S1_RDATA = r_grant[1] ? w_rdata : '0;
  assign S1_RRESP = r_grant[1] ? w_rresp : '0;
  assign w_aw_hs = M_AWVALID & M_AWREADY;
  assign w_w_hs = M_WVALID & M_WREADY;
  assign w_b_hs = M_BREADY & M_BVALID;
  assign w_ar_hs = M_ARVALID & M_ARREADY;
  assign w_r_hs = w_in_rdata & M_RVALID & M_RREADY;
  assign w_wr_end = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
  assign w_done = w_b_hs | w_r_hs;
  assign GRANT = r_grant;
  assign BUSY = r_state != IDLE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (w_req0 | w_req1) ? (w_win_aw ? WR : RD) : IDLE;
      WR:      w_next = w_wr_end ? WRESP : WR;
      WRESP:   w_next = w_b_hs ? IDLE : WRESP;
      RD:      w_next = w_ar_hs ? RDATA : RD;
      RDATA:   w_next = w_r_hs ? IDLE : RDATA;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && (w_req0 | w_req1)) r_grant <= w_win ? 2'b10 : 2'b01;
      else if (w_done) r_grant <= '0;
      if (w_done) r_ptr <= ~w_sel;
      r_aw_done <= w_in_wr & ~w_wr_end & (r_aw_done | w_aw_hs);
      r_w_done <= w_in_wr & ~w_wr_end & (r_w_done | w_w_hs);
    end
  end
endmodule
